// File: rtl/uart_xbus_bridge_if.sv
// xbus initiator/target bundle used by the UART-to-xbus bridge.
`ifndef XADDRW
`define XADDRW 32
`endif
`ifndef XDATAW
`define XDATAW 32
`endif
`ifndef XBYTEC
`define XBYTEC 4
`endif

interface uart_xbus_bridge_if;
   logic               cs;
   logic               we;
   logic [`XBYTEC-1:0] be;
   logic [`XADDRW-1:0] addr;
   logic [`XDATAW-1:0] wdata;
   logic [`XDATAW-1:0] rdata;

   modport master (output cs, output we, output be, output addr, output wdata, input rdata);
   modport slave  (input cs, input we, input be, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_xbus_bridge.sv
// UART command parser: WRITE/READ frames become single-cycle xbus accesses,
// answered with ACK, NAK or the read data over the UART transmitter.
`ifndef XADDRW
`define XADDRW 32
`endif
`ifndef XDATAW
`define XDATAW 32
`endif
`ifndef XBYTEC
`define XBYTEC 4
`endif

module uart_xbus_bridge #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx_end,
   input  logic [7:0]                rx_data,
   output logic                      tx_start,
   output logic [7:0]                tx_data,
   input  logic                      tx_ready,
   uart_xbus_bridge_if.master        xbus,
   output logic                      busy
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD_ERR = 3'd1,
      ADDR    = 3'd2,
      DATA    = 3'd3,
      BUS     = 3'd4,
      RESP    = 3'd5,
      TXWAIT  = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic               is_rd_q, is_rd_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [TW-1:0]      tmo_q, tmo_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        resp_q, resp_d;
   logic [2:0]         left_q, left_d;
   logic               tx_start_q, tx_start_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               cs_q, cs_d;
   logic               we_q, we_d;
   logic [`XBYTEC-1:0] be_q, be_d;
   logic [31:0]        xaddr_q, xaddr_d;
   logic [31:0]        xwdata_q, xwdata_d;
   logic               busy_q, busy_d;

   // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
   always_comb begin
      state_d    = state_q;
      is_rd_d    = is_rd_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      resp_d     = resp_q;
      left_d     = left_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      cs_d       = 1'b0;
      we_d       = 1'b0;
      be_d       = {`XBYTEC{1'b0}};
      xaddr_d    = xaddr_q;
      xwdata_d   = xwdata_q;

      case (state_q)
         IDLE: begin
            tmo_d = {TW{1'b0}};
            if (rx_end) begin
               if (rx_data == 8'h57 || rx_data == 8'h52) begin
                  is_rd_d = (rx_data == 8'h52);
                  cnt_d   = 2'd0;
                  state_d = ADDR;
               end else begin
                  state_d = CMD_ERR;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CMD_ERR: begin
            resp_d  = 32'h0000_0015;
            left_d  = 3'd1;
            state_d = RESP;
         end
         ADDR, DATA: begin
            // A byte arriving on the timeout cycle wins over the timeout.
            if (rx_end) begin
               tmo_d = {TW{1'b0}};
               cnt_d = cnt_q + 2'd1;
               if (state_q == ADDR) begin
                  addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
               end else begin
                  wdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
               end
               if (cnt_q == 2'd3) begin
                  state_d = (state_q == ADDR && !is_rd_q) ? DATA : BUS;
               end else begin
                  state_d = state_q;
               end
            end else if (tmo_q == TMO_LAST) begin
               tmo_d   = {TW{1'b0}};
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
            end
         end
         BUS: begin
            resp_d  = is_rd_q ? xbus.rdata : 32'h0000_0006;
            left_d  = is_rd_q ? 3'd4 : 3'd1;
            state_d = RESP;
         end
         RESP: begin
            if (tx_ready) begin
               tx_start_d = 1'b1;
               tx_data_d  = resp_q[7:0];
               resp_d     = {8'h00, resp_q[31:8]};
               left_d     = left_q - 3'd1;
               state_d    = TXWAIT;
            end else begin
               state_d = RESP;
            end
         end
         TXWAIT: begin
            if (!tx_ready) begin
               state_d = (left_q == 3'd0) ? IDLE : RESP;
            end else begin
               state_d = TXWAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d == BUS) begin
         cs_d     = 1'b1;
         we_d     = !is_rd_d;
         be_d     = {`XBYTEC{1'b1}};
         xaddr_d  = addr_d;
         xwdata_d = wdata_d;
      end else begin
         cs_d = 1'b0;
         we_d = 1'b0;
         be_d = {`XBYTEC{1'b0}};
      end
      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         is_rd_q    <= 1'b0;
         cnt_q      <= 2'd0;
         tmo_q      <= {TW{1'b0}};
         addr_q     <= 32'h0000_0000;
         wdata_q    <= 32'h0000_0000;
         resp_q     <= 32'h0000_0000;
         left_q     <= 3'd0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         cs_q       <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= {`XBYTEC{1'b0}};
         xaddr_q    <= 32'h0000_0000;
         xwdata_q   <= 32'h0000_0000;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_rd_q    <= is_rd_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         resp_q     <= resp_d;
         left_q     <= left_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         cs_q       <= cs_d;
         we_q       <= we_d;
         be_q       <= be_d;
         xaddr_q    <= xaddr_d;
         xwdata_q   <= xwdata_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign xbus.cs    = cs_q;
   assign xbus.we    = we_q;
   assign xbus.be    = be_q;
   assign xbus.addr  = xaddr_q;
   assign xbus.wdata = xwdata_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_xbus_bridge.sv
// Directed bench for uart_xbus_bridge: a frame-level model predicts bus cycles
// and reply bytes, and a per-cycle monitor checks the DUT against it.
module tb_uart_xbus_bridge;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_end;
   logic [7:0]  rx_data;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        busy;
   logic        hold;
   logic [31:0] rd_val;

   int vectors = 0;
   int miscompares = 0;
   int cs_count = 0;
   int tx_cnt = 0;

   bus_t        exp_bus[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  tx_log[$];
   logic [7:0]  frm[$];
   bus_t        last_bus;
   logic [3:0]  last_be;

   uart_xbus_bridge_if xb();

   uart_xbus_bridge #(.TIMEOUT_CYC(50)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_end   (rx_end),
      .rx_data  (rx_data),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .xbus     (xb),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   assign xb.rdata = rd_val;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Frame-level model: what a complete frame must produce on the bus and the UART.
   task automatic model_frame();
      logic [31:0] a;
      logic [31:0] d;
      bus_t        b;
      if (frm[0] == 8'h57 && frm.size() == 9) begin
         a = {frm[4], frm[3], frm[2], frm[1]};
         d = {frm[8], frm[7], frm[6], frm[5]};
         b.we = 1'b1; b.addr = a; b.wdata = d;
         exp_bus.push_back(b);
         exp_tx.push_back(8'h06);
      end else if (frm[0] == 8'h52 && frm.size() == 5) begin
         a = {frm[4], frm[3], frm[2], frm[1]};
         b.we = 1'b0; b.addr = a; b.wdata = 32'h0;
         exp_bus.push_back(b);
         for (int i = 0; i < 4; i++) exp_tx.push_back(rd_val[8*i +: 8]);
      end else begin
         exp_tx.push_back(8'h15);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_end  = 1'b1;
      rx_data = b;
      @(negedge clk);
      rx_end  = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_frame(input bit use_model);
      if (use_model) model_frame();
      for (int i = 0; i < frm.size(); i++) send_byte(frm[i]);
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n;
      n = 0;
      while ((exp_bus.size() != 0 || exp_tx.size() != 0 || busy !== 1'b0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (n >= limit) begin
         miscompares++;
         $display("FAIL %s: still busy/pending after %0d cycles (bus=%0d tx=%0d), expected idle",
                  name, n, exp_bus.size(), exp_tx.size());
      end
      exp_bus.delete();
      exp_tx.delete();
   endtask

   // Per-cycle monitor plus transmitter model.
   initial begin
      bus_t e;
      tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (xb.cs === 1'b1) begin
            cs_count++;
            last_bus.we = xb.we; last_bus.addr = xb.addr; last_bus.wdata = xb.wdata;
            last_be = xb.be;
            if (exp_bus.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL bus_unexpected: got cs=1 addr=%h, expected no bus cycle", xb.addr);
            end else begin
               e = exp_bus.pop_front();
               chk("bus_addr", xb.addr, e.addr);
               chk("bus_we", {31'd0, xb.we}, {31'd0, e.we});
               chk("bus_be", {28'd0, xb.be}, 32'h0000_000F);
               if (e.we) chk("bus_wdata", xb.wdata, e.wdata);
            end
         end
         if (tx_start === 1'b1) begin
            tx_log.push_back(tx_data);
            chk("tx_ready_at_start", {31'd0, tx_ready}, 32'd1);
            if (exp_tx.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL tx_unexpected: got tx_start with %h, expected none", tx_data);
            end else begin
               chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
            tx_cnt = 6;
         end else if (tx_cnt > 0) begin
            tx_cnt--;
         end
         tx_ready = !hold && (tx_cnt == 0) && (tx_start !== 1'b1);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
      chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
      chk({tag, "_cs"}, {31'd0, xb.cs}, 32'd0);
      chk({tag, "_we"}, {31'd0, xb.we}, 32'd0);
      chk({tag, "_be"}, {28'd0, xb.be}, 32'd0);
      chk({tag, "_addr"}, xb.addr, 32'd0);
      chk({tag, "_wdata"}, xb.wdata, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int c0;
      rst_n = 1'b0; rx_end = 1'b0; rx_data = 8'h00; hold = 1'b0; rd_val = 32'h0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // WRITE frame
      tx_log.delete();
      frm = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_frame(1'b1);
      wait_idle("write_done", 200);
      chk("write_addr_lit", last_bus.addr, 32'h8000_0010);
      chk("write_wdata_lit", last_bus.wdata, 32'hDEAD_BEEF);
      chk("write_we_lit", {31'd0, last_bus.we}, 32'd1);
      chk("write_be_lit", {28'd0, last_be}, 32'h0000_000F);
      chk("write_ack_len", tx_log.size(), 32'd1);
      if (tx_log.size() > 0) chk("write_ack_lit", {24'd0, tx_log[0]}, 32'h0000_0006);

      // READ frame
      tx_log.delete();
      rd_val = 32'h0000_0003;
      frm = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h80};
      send_frame(1'b1);
      wait_idle("read_done", 300);
      chk("read_addr_lit", last_bus.addr, 32'h8000_0004);
      chk("read_we_lit", {31'd0, last_bus.we}, 32'd0);
      chk("read_len", tx_log.size(), 32'd4);
      if (tx_log.size() == 4)
         chk("read_bytes_lit", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h0300_0000);

      // Bad command then a normal WRITE
      tx_log.delete();
      c0 = cs_count;
      frm = '{8'h41};
      send_frame(1'b1);
      wait_idle("nak_done", 200);
      chk("nak_no_cs", cs_count - c0, 32'd0);
      chk("nak_len", tx_log.size(), 32'd1);
      if (tx_log.size() > 0) chk("nak_lit", {24'd0, tx_log[0]}, 32'h0000_0015);
      frm = '{8'h57, 8'h44, 8'h33, 8'h22, 8'h11, 8'h78, 8'h56, 8'h34, 8'h12};
      send_frame(1'b1);
      wait_idle("after_nak_write", 200);
      chk("after_nak_addr", last_bus.addr, 32'h1122_3344);
      chk("after_nak_wdata", last_bus.wdata, 32'h1234_5678);

      // Inter-byte timeout
      tx_log.delete();
      c0 = cs_count;
      frm = '{8'h57, 8'h10, 8'h00};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); rx_end = 1'b1; rx_data = frm[i];
         @(negedge clk); rx_end = 1'b0;
      end
      repeat (45) @(negedge clk);
      chk("tmo_still_busy", {31'd0, busy}, 32'd1);
      repeat (10) @(negedge clk);
      chk("tmo_idle", {31'd0, busy}, 32'd0);
      chk("tmo_no_cs", cs_count - c0, 32'd0);
      chk("tmo_no_tx", tx_log.size(), 32'd0);
      rd_val = 32'hA1B2_C3D4;
      frm = '{8'h52, 8'h03, 8'h00, 8'h00, 8'h40};
      send_frame(1'b1);
      wait_idle("after_tmo_read", 300);
      chk("after_tmo_addr", last_bus.addr, 32'h4000_0003);

      // Back-pressure on a READ reply, with bytes injected meanwhile
      tx_log.delete();
      hold = 1'b1;
      rd_val = 32'h1122_3344;
      frm = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h80};
      send_frame(1'b1);
      c0 = cs_count;
      frm = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      send_frame(1'b0);
      repeat (164) @(negedge clk);
      chk("bp_no_tx_while_held", tx_log.size(), 32'd0);
      chk("bp_busy_while_held", {31'd0, busy}, 32'd1);
      hold = 1'b0;
      wait_idle("bp_done", 300);
      chk("bp_no_extra_cs", cs_count - c0, 32'd0);
      chk("bp_len", tx_log.size(), 32'd4);
      if (tx_log.size() == 4)
         chk("bp_bytes_lit", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h4433_2211);

      // Reset mid-DATA then a full WRITE
      tx_log.delete();
      c0 = cs_count;
      frm = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h80, 8'hAA};
      send_frame(1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midrst");
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      chk("midrst_no_cs", cs_count - c0, 32'd0);
      chk("midrst_no_tx", tx_log.size(), 32'd0);
      frm = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h80, 8'h67, 8'h45, 8'h23, 8'h01};
      send_frame(1'b1);
      wait_idle("midrst_write", 200);
      chk("midrst_addr", last_bus.addr, 32'h8000_0020);
      chk("midrst_wdata", last_bus.wdata, 32'h0123_4567);
      chk("midrst_ack", tx_log.size(), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_xbus_bridge.md
UART_XBUS_BRIDGE -- requirements
Module: uart_xbus_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 100000, the maximum number of idle cycles allowed between bytes inside one frame.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port rx_end, input, 1 bit: one-cycle strobe meaning a received byte is valid on rx_data.
REQ-005 The block SHALL have port rx_data, input, 8 bits: the received byte.
REQ-006 The block SHALL have port tx_start, output, 1 bit: one-cycle pulse requesting transmission of tx_data.
REQ-007 The block SHALL have port tx_data, output, 8 bits: the byte to transmit, held stable from tx_start until tx_ready rises again.
REQ-008 The block SHALL have port tx_ready, input, 1 bit: transmitter idle; it falls in the cycle after tx_start.
REQ-009 The block SHALL have ports xbus_cs, xbus_we (outputs, 1 bit), xbus_be (output, `XBYTEC), xbus_addr (output, `XADDRW), xbus_wdata (output, `XDATAW) and xbus_rdata (input, `XDATAW), forming the xbus initiator port.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-011 Frame formats: WRITE = 0x57, addr[4 bytes], data[4 bytes]; READ = 0x52, addr[4 bytes]; all multi-byte fields are sent little-endian (LSB first).
REQ-012 The FSM SHALL implement the states IDLE, CMD_ERR, ADDR, DATA, BUS, RESP and TXWAIT.
REQ-013 In IDLE, rx_end with 0x57 or 0x52 SHALL latch the command, clear the byte counter and move the FSM to ADDR.
REQ-014 In IDLE, rx_end with any other byte SHALL move the FSM to CMD_ERR, which queues the single reply 0x15 (NAK) and then returns to IDLE with no bus cycle.
REQ-015 ADDR SHALL shift in 4 bytes, placing byte k at addr[8k+7:8k], then go to DATA for WRITE or to BUS for READ.
REQ-016 DATA SHALL shift in 4 bytes into wdata in the same way and then go to BUS.
REQ-017 BUS SHALL last exactly one cycle: xbus_cs=1, xbus_be=4'hF, xbus_we=1 for WRITE and 0 for READ, xbus_addr and xbus_wdata taken from the latched registers.
REQ-018 For READ, xbus_rdata SHALL be captured in that same BUS cycle.
REQ-019 Outside BUS, xbus_cs and xbus_we SHALL be 0; xbus_addr and xbus_wdata hold their last values.
REQ-020 The response after a WRITE SHALL be 1 byte, 0x06 (ACK); after a READ it SHALL be 4 bytes of captured rdata, LSB first.
REQ-021 RESP SHALL pulse tx_start only while tx_ready=1; TXWAIT waits for tx_ready=0, then the FSM returns to RESP for the next byte, or to IDLE after the last byte.
REQ-022 A WRITE frame SHALL have latency from the last data-byte rx_end to xbus_cs of exactly 1 cycle; a READ frame SHALL have the same latency measured from the last address byte.
REQ-023 Inter-byte timeout: in ADDR or DATA, a counter SHALL reset on every rx_end; on reaching TIMEOUT_CYC the FSM SHALL return to IDLE with no bus cycle and no reply.
REQ-024 rx_end in BUS, RESP, TXWAIT or CMD_ERR SHALL be discarded and SHALL NOT start a new frame.
REQ-025 rx_end in the same cycle as a timeout SHALL take precedence: the byte is accepted and the counter is cleared.
REQ-026 The address SHALL pass to xbus_addr unmodified, with no alignment check.

Reset
REQ-027 rst_n=0 SHALL immediately force: FSM to IDLE, tx_start=0, tx_data=0, xbus_cs=0, xbus_we=0, xbus_be=0, xbus_addr=0, xbus_wdata=0, busy=0, all counters to 0.
REQ-028 Reset asserted mid-frame or mid-response SHALL abandon the frame; after release the next byte SHALL be parsed as a command.

Verification
REQ-029 WRITE: send 57 10 00 00 80 EF BE AD DE -> exactly one xbus cycle with cs=1, we=1, be=F, addr=0x80000010, wdata=0xDEADBEEF; tx then sends 0x06.
REQ-030 READ: send 52 04 00 00 80 with xbus_rdata=0x00000003 in the BUS cycle -> cs=1, we=0, addr=0x80000004; tx sends 03 00 00 00 in order.
REQ-031 Bad command: send 0x41 -> no xbus_cs; tx sends 0x15; the following valid WRITE frame completes normally.
REQ-032 Timeout: set TIMEOUT_CYC=50, send 57 10 00, then stall 50 cycles -> FSM returns to IDLE and busy=0 with no cs and no tx; a following READ frame completes normally.
REQ-033 Back-pressure: hold tx_ready=0 during a READ response for 200 cycles -> no tx_start while tx_ready=0; all 4 bytes are sent in order once it is released; bytes injected meanwhile are ignored.
REQ-034 Reset mid-DATA: pulse rst_n low after 6 bytes of a WRITE -> all outputs return to reset values, no bus cycle occurs, and a subsequent full WRITE succeeds.
